// File: rtl/student_logic16_seq.sv
// Two-requester bit-serial 16-bit logic unit: one operation at a time is
// evaluated LSB-first through a single 1-bit NAND-only function unit.

module nand_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule

module mux2_nand (
  input  logic d0,
  input  logic d1,
  input  logic s,
  output logic y
);
  logic ns, t0, t1;
  nand_gate u_inv (.a(s),  .b(s),  .y(ns));
  nand_gate u_t1  (.a(d1), .b(s),  .y(t1));
  nand_gate u_t0  (.a(d0), .b(ns), .y(t0));
  nand_gate u_out (.a(t0), .b(t1), .y(y));
endmodule

// 00 NOT a, 01 AND, 10 OR, 11 XOR -- every gate, selection included, is a NAND.
module bit_alu (
  input  logic       a,
  input  logic       b,
  input  logic [1:0] op,
  output logic       y
);
  logic na, nb, nab, and_y, or_y, x1, x2, xor_y, m0, m1;
  nand_gate u_na  (.a(a),   .b(a),   .y(na));
  nand_gate u_nb  (.a(b),   .b(b),   .y(nb));
  nand_gate u_nab (.a(a),   .b(b),   .y(nab));
  nand_gate u_and (.a(nab), .b(nab), .y(and_y));
  nand_gate u_or  (.a(na),  .b(nb),  .y(or_y));
  nand_gate u_x1  (.a(a),   .b(nab), .y(x1));
  nand_gate u_x2  (.a(b),   .b(nab), .y(x2));
  nand_gate u_xor (.a(x1),  .b(x2),  .y(xor_y));
  mux2_nand u_m0  (.d0(na),   .d1(and_y), .s(op[0]), .y(m0));
  mux2_nand u_m1  (.d0(or_y), .d1(xor_y), .s(op[0]), .y(m1));
  mux2_nand u_m2  (.d0(m0),   .d1(m1),    .s(op[1]), .y(y));
endmodule

module student_logic16_seq #(
  parameter int FAIR = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_op,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_op,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [15:0] resp_data,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;
  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
  } req_t;

  state_t     state, state_nxt;
  req_t       req_q;
  logic [3:0] cnt;
  logic       last_grant, grant, accept, f_bit;

  // Ready is gated by rst_n so both readys read 0 throughout reset.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid)
      grant = (FAIR != 0) ? ~last_grant : 1'b0;
    req0_ready = rst_n && (state == IDLE) && req0_valid && !grant;
    req1_ready = rst_n && (state == IDLE) && req1_valid && grant;
    accept     = req0_ready || req1_ready;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (cnt == 4'd15) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  bit_alu u_alu (.a(req_q.a[cnt]), .b(req_q.b[cnt]), .op(req_q.op), .y(f_bit));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q      <= '0;
      cnt        <= 4'd0;
      last_grant <= 1'b1;
      resp_id    <= 1'b0;
      resp_data  <= 16'd0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          req_q      <= grant ? {req1_op, req1_a, req1_b} : {req0_op, req0_a, req0_b};
          resp_id    <= grant;
          last_grant <= grant;
          resp_data  <= 16'd0;
          cnt        <= 4'd0;
        end
        RUN: begin
          resp_data[cnt] <= f_bit;
          if (cnt != 4'd15) cnt <= cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);
endmodule
